// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect input, decode-side head
// handshake and status. The master modport belongs to the fetch queue.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [5:0]    imem_a;
    logic [31:0]   imem_rd;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          deq_ready;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic [CW-1:0] count;
    logic          fetch_oor;
    logic          misalign;

    modport master (
        output imem_a,
        input  imem_rd,
        input  redirect,
        input  redirect_pc,
        input  deq_ready,
        output instr_valid,
        output instr,
        output instr_pc,
        output count,
        output fetch_oor,
        output misalign
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        output redirect,
        output redirect_pc,
        output deq_ready,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  count,
        input  fetch_oor,
        input  misalign
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential words into a small FIFO,
// flushes and refetches on redirect, halts fetch past the populated memory.
module ifetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_WORDS = 40
) (
    input logic           clk,
    input logic           reset,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [29:0]   MEM_WORDS_C = 30'(MEM_WORDS);

    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          fetch_oor_q, fetch_oor_d;
    logic          misalign_q, misalign_d;

    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic          pop;
    logic          push;
    logic          oor_now;

    always_comb begin
        pop     = (count_q != '0) && bus.deq_ready && !bus.redirect;
        oor_now = (fpc_q[31:2] >= MEM_WORDS_C);
        push    = !bus.redirect && !fetch_oor_q && !oor_now &&
                  ((count_q < DEPTH_C) || pop);

        fpc_d       = fpc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fetch_oor_d = fetch_oor_q;
        misalign_d  = 1'b0;

        if (bus.redirect) begin
            // Redirect wins over everything: flush and restart at the word-aligned target.
            fpc_d       = {bus.redirect_pc[31:2], 2'b00};
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            fetch_oor_d = 1'b0;
            misalign_d  = |bus.redirect_pc[1:0];
        end else begin
            if (oor_now) begin
                fetch_oor_d = 1'b1;
            end
            if (push) begin
                fpc_d    = fpc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q       <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fetch_oor_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fetch_oor_q <= fetch_oor_d;
            misalign_q  <= misalign_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wr_ptr_q]  <= fpc_q;
            ins_mem_q[wr_ptr_q] <= bus.imem_rd;
        end
    end

    assign bus.imem_a      = fpc_q[7:2];
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? ins_mem_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? pc_mem_q[rd_ptr_q]  : 32'h0;
    assign bus.count       = count_q;
    assign bus.fetch_oor   = fetch_oor_q;
    assign bus.misalign    = misalign_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with fixed expectations plus a
// randomized run compared against a queue-based reference model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int MEM_WORDS = 40;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] imem [64];

    int n_vec = 0;
    int n_err = 0;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic        m_oor;
    logic        m_mis;

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(32'h0),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rd = imem[bus.imem_a];

    // Apply one cycle of inputs, clock, and advance the reference model.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic dq);
        bit   pop, push, inrange, oor_old;
        ent_t e;
        reset           = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.deq_ready   = dq;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_fpc = 32'h0;
            m_oor = 1'b0;
            m_mis = 1'b0;
        end else if (rd) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
            m_oor = 1'b0;
            m_mis = (rpc[1:0] != 2'b00);
        end else begin
            m_mis   = 1'b0;
            inrange = (m_fpc / 4) < MEM_WORDS;
            oor_old = m_oor;
            if (!inrange) m_oor = 1'b1;
            pop  = (mq.size() > 0) && dq;
            push = !oor_old && inrange && ((mq.size() < DEPTH) || pop);
            e.pc  = m_fpc;
            e.ins = 32'h2000_0000 + ((m_fpc / 4) % 64);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
        reset        = 1'b0;
        bus.redirect = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h44, 1'b1);
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.instr_valid); end
        n_vec++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", bus.instr); end
        n_vec++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.instr_pc); end
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_vec++; if (bus.imem_a !== 6'd0) begin n_err++; $display("FAIL reset_imem_a got %0d want 0", bus.imem_a); end
        n_vec++; if ({bus.fetch_oor, bus.misalign} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {bus.fetch_oor, bus.misalign}); end
    endtask

    task automatic test_stream();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i) || bus.instr !== 32'h2000_0000 + 32'(i)) begin
                n_err++;
                $display("FAIL stream_%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, 4 * i, 32'h2000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL stall_count got %0d want 4", bus.count); end
        n_vec++; if (bus.imem_a !== 6'd4) begin n_err++; $display("FAIL stall_imem_a got %0d want 4", bus.imem_a); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i)) begin
                n_err++;
                $display("FAIL stall_release_%0d got v=%0b pc=%h want v=1 pc=%h", i, bus.instr_valid, bus.instr_pc, 4 * i);
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count got %0d want 3", bus.count); end
        step(1'b0, 1'b1, 32'h40, 1'b0);
        n_vec++;
        if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0 || bus.imem_a !== 6'd16) begin
            n_err++;
            $display("FAIL redir_flush got cnt=%0d v=%0b a=%0d want cnt=0 v=0 a=16", bus.count, bus.instr_valid, bus.imem_a);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr !== 32'h2000_0010) begin
            n_err++;
            $display("FAIL redir_target got v=%0b pc=%h ins=%h want v=1 pc=40 ins=20000010", bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_misalign();
        step(1'b0, 1'b1, 32'h92, 1'b1);
        n_vec++; if (bus.misalign !== 1'b1) begin n_err++; $display("FAIL misalign_pulse got %0b want 1", bus.misalign); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++; if (bus.misalign !== 1'b0) begin n_err++; $display("FAIL misalign_clear got %0b want 0", bus.misalign); end
        n_vec++;
        if (bus.instr_pc !== 32'h90 || bus.instr !== 32'h2000_0024) begin
            n_err++;
            $display("FAIL misalign_target got pc=%h ins=%h want pc=90 ins=20000024", bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 1'b1, 32'h20, 1'b1);
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL b2b_flush got cnt=%0d want 0", bus.count); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++; if (bus.instr_pc !== 32'h20) begin n_err++; $display("FAIL b2b_target got pc=%h want 20", bus.instr_pc); end
    endtask

    task automatic test_oor();
        step(1'b0, 1'b1, 32'h90, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.fetch_oor !== 1'b1 || bus.count !== 3'd0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin
            n_err++;
            $display("FAIL oor_set got oor=%0b cnt=%0d v=%0b ins=%h want oor=1 cnt=0 v=0 ins=0",
                     bus.fetch_oor, bus.count, bus.instr_valid, bus.instr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.fetch_oor !== 1'b1 || bus.imem_a !== 6'd40) begin
            n_err++;
            $display("FAIL oor_hold got oor=%0b a=%0d want oor=1 a=40", bus.fetch_oor, bus.imem_a);
        end
        step(1'b0, 1'b1, 32'h0, 1'b1);
        n_vec++; if (bus.fetch_oor !== 1'b0) begin n_err++; $display("FAIL oor_clear got %0b want 0", bus.fetch_oor); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            n_err++;
            $display("FAIL oor_resume got v=%0b pc=%h want v=1 pc=0", bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_reset_flush();
        step(1'b0, 1'b1, 32'h30, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL rstflush_full got cnt=%0d want 4", bus.count); end
        step(1'b1, 1'b1, 32'h40, 1'b0);
        n_vec++;
        if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0 || bus.imem_a !== 6'd0) begin
            n_err++;
            $display("FAIL rstflush_clear got cnt=%0d v=%0b a=%0d want cnt=0 v=0 a=0", bus.count, bus.instr_valid, bus.imem_a);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.count !== 3'd1) begin
            n_err++;
            $display("FAIL rstflush_restart got v=%0b pc=%h cnt=%0d want v=1 pc=0 cnt=1", bus.instr_valid, bus.instr_pc, bus.count);
        end
    endtask

    task automatic test_random();
        logic        r, rd, dq;
        logic [31:0] rpc;
        logic [31:0] e_ins, e_pc;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 99) < 6);
            dq  = ($urandom_range(0, 99) < 65);
            rpc = 32'($urandom_range(0, 44)) * 32'd4;
            if ($urandom_range(0, 3) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            step(r, rd, rpc, dq);
            e_pc  = (mq.size() > 0) ? mq[0].pc  : 32'h0;
            e_ins = (mq.size() > 0) ? mq[0].ins : 32'h0;
            n_vec++;
            if (bus.instr_valid !== (mq.size() > 0) || bus.instr_pc !== e_pc || bus.instr !== e_ins) begin
                n_err++;
                $display("FAIL rand_head_%0d got v=%0b pc=%h ins=%h want v=%0b pc=%h ins=%h",
                         n, bus.instr_valid, bus.instr_pc, bus.instr, mq.size() > 0, e_pc, e_ins);
            end
            n_vec++;
            if (bus.count !== 3'(mq.size()) || bus.imem_a !== m_fpc[7:2]) begin
                n_err++;
                $display("FAIL rand_cnt_%0d got cnt=%0d a=%0d want cnt=%0d a=%0d",
                         n, bus.count, bus.imem_a, mq.size(), m_fpc[7:2]);
            end
            n_vec++;
            if (bus.fetch_oor !== m_oor || bus.misalign !== m_mis) begin
                n_err++;
                $display("FAIL rand_flags_%0d got oor=%0b mis=%0b want oor=%0b mis=%0b",
                         n, bus.fetch_oor, bus.misalign, m_oor, m_mis);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) imem[k] = 32'h2000_0000 + 32'(k);
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.deq_ready   = 1'b0;
        m_fpc = 32'h0;
        m_oor = 1'b0;
        m_mis = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_back_to_back();
        test_oor();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0, byte address fetched first after reset.
REQ-003 Parameter MEM_WORDS, default 40, number of populated instruction-memory words.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 imem_a  out  6  word index to instruction memory, equal to fpc[7:2].
REQ-007 imem_rd  in  32  instruction word, combinational from imem_a in the same cycle.
REQ-008 redirect  in  1  taken branch/jump; flush queue and refetch.
REQ-009 redirect_pc  in  32  byte target of redirect.
REQ-010 deq_ready  in  1  decode accepts head entry this cycle (low = stall).
REQ-011 instr_valid  out  1  head entry present.
REQ-012 instr  out  32  head instruction; 32'h0 when instr_valid=0.
REQ-013 instr_pc  out  32  byte PC of head instruction; 32'h0 when instr_valid=0.
REQ-014 count  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-015 fetch_oor  out  1  sticky: fetch halted because fpc[31:2] >= MEM_WORDS.
REQ-016 misalign  out  1  one-cycle pulse: a redirect_pc with nonzero bits [1:0] was accepted.

Function
REQ-017 Internal fetch PC fpc (32 bit, byte address, bits [1:0] always 0); imem_a = fpc[7:2] combinationally.
REQ-018 Pop occurs when instr_valid && deq_ready && !redirect.
REQ-019 Push occurs when !redirect && !fetch_oor && (count < DEPTH || pop); pushed entry = {fpc, imem_rd}; fpc <= fpc + 4.
REQ-020 Push when full is permitted only with a simultaneous pop; count unchanged.
REQ-021 Simultaneous push and pop when count=0 not possible (no pop when empty); pushed entry becomes visible next cycle (no bypass).
REQ-022 count updates: +1 push only, -1 pop only, unchanged both or neither; never exceeds DEPTH, never below 0.
REQ-023 Queue is FIFO; read/write pointers wrap modulo DEPTH.
REQ-024 Redirect has priority over all: queue cleared (count <= 0), no push, no pop in that cycle, fpc <= {redirect_pc[31:2], 2'b00}, fetch_oor <= 0.
REQ-025 misalign <= 1 for exactly the cycle after a redirect with redirect_pc[1:0] != 0, else 0.
REQ-026 Redirect latency: redirect at cycle N -> target fetched in N+1 -> instr_valid=1 with instr_pc=target in N+2.
REQ-027 Back-to-back redirects: last one wins; each flushes anything pushed in between.
REQ-028 If not redirecting and fpc[31:2] >= MEM_WORDS, set fetch_oor <= 1 and suppress push; queue still drains normally; fpc holds.
REQ-029 fpc wraps mod 2^32 at 32'hFFFF_FFFC; imem_a thus wraps mod 64 words.
REQ-030 Steady state with deq_ready held high: one instruction delivered per cycle, sequential instr_pc stepping by 4.
REQ-031 Stall (deq_ready=0): head, instr, instr_pc stable; fetch continues until count = DEPTH, then imem_a holds.

Reset
REQ-032 reset=1 at a rising edge: fpc <= RESET_PC, count <= 0, pointers <= 0, fetch_oor <= 0, misalign <= 0; outputs instr_valid=0, instr=0, instr_pc=0, imem_a=RESET_PC[7:2] the following cycle.
REQ-033 Reset overrides redirect and any in-flight push/pop; first push occurs at the first edge with reset=0; instr_valid=1 on the cycle after.
REQ-034 Reset asserted mid-stall or mid-redirect discards all queue contents; no stale entry is presented after deassertion.

Verification
REQ-035 Reset, deq_ready=1, imem words k -> 32'h2000_0000+k: instr_pc 0,4,8,... one per cycle, instr matches, first valid one cycle after reset release.
REQ-036 deq_ready=0 for 10 cycles after reset: count reaches 4, imem_a holds 4, head stays instr_pc=0; release -> delivers 0,4,8,12,16 without gap.
REQ-037 Redirect to 32'h40 while count=3: next cycle count=0, instr_valid=0, imem_a=16; cycle after instr_valid=1, instr_pc=32'h40.
REQ-038 Redirect to 32'h92 -> misalign pulses one cycle, instr_pc=32'h90 two cycles later.
REQ-039 Sequential fetch reaching fpc=160 (word 40): fetch_oor=1, queue drains to 0, instr_valid=0; redirect to 0 clears fetch_oor and resumes.
REQ-040 Reset asserted while full and stalled, plus simultaneous redirect: after release, count=0, fetch restarts at RESET_PC, no flushed entry appears.
